// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: x1 - x2 - bin, one bit per clock, LSB first.
// Flags (bout, ovf, zero) and y are registered when the last bit completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_n;
  logic [WIDTH-1:0] res_n;

  always_comb begin
    d     = a[0] ^ b[0] ^ br;
    br_n  = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
    res_n = {d, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      br    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a     <= x1;
            b     <= x2;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a   <= a >> 1;
          b   <= b >> 1;
          br  <= br_n;
          res <= res_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // a[0]/b[0] now hold the operand MSBs
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            y     <= res_n;
            bout  <= br_n;
            ovf   <= (a[0] ^ b[0]) & (d ^ a[0]);
            zero  <= ~|res_n;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (>=2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction.
REQ-005 SHALL have port: x1  input  WIDTH  minuend.
REQ-006 SHALL have port: x2  input  WIDTH  subtrahend.
REQ-007 SHALL have port: bin  input  1  borrow-in.
REQ-008 SHALL have port: busy  output  1  high while an operation is in flight.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port: y  output  WIDTH  difference, x1 - x2 - bin, modulo 2^WIDTH.
REQ-011 SHALL have port: bout  output  1  borrow-out (unsigned x1 < x2 + bin).
REQ-012 SHALL have port: ovf  output  1  signed two's-complement overflow.
REQ-013 SHALL have port: zero  output  1  high when y == 0.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with start=1, register x1, x2, bin, clear the bit counter, enter RUN; busy=1 from the next cycle.
REQ-016 SHALL, in RUN, process one bit per clock, LSB first, using a full-subtractor: d = a^b^br; br' = (~a&b) | (~(a^b)&br).
REQ-017 SHALL take exactly WIDTH RUN cycles; on the edge completing bit WIDTH-1, enter DONE and update y, bout, ovf, zero.
REQ-018 SHALL assert done only in DONE, for exactly one cycle, with busy=0; next edge returns to IDLE.
REQ-019 SHALL give latency: done high in the cycle after the WIDTH-th edge following the start-sampling edge (8 for WIDTH=8).
REQ-020 SHALL compute ovf = (x1[MSB]^x2[MSB]) & (y[MSB]^x1[MSB]) on the captured operands.
REQ-021 SHALL ignore start in RUN and DONE; captured operands are not altered by input changes after capture.
REQ-022 SHALL hold y, bout, ovf, zero stable from done until the next done; they are not cleared at start.
REQ-023 SHALL accept back-to-back operations: start sampled in the IDLE cycle immediately after DONE is accepted.
REQ-024 SHALL keep busy high in every RUN cycle and low in IDLE and DONE.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, enter IDLE and set busy=0, done=0, y=0, bout=0, ovf=0, zero=0, counter=0.
REQ-026 SHALL give rst priority over start in the same cycle.
REQ-027 SHALL, on rst mid-RUN, discard the in-flight operation with no done pulse.

Verification
REQ-028 SHALL verify: x1=8'h05, x2=8'h03, bin=0, start -> done 8 cycles later, y=8'h02, bout=0, ovf=0, zero=0.
REQ-029 SHALL verify: x1=8'h00, x2=8'h01, bin=0 -> y=8'hFF, bout=1, ovf=0, zero=0.
REQ-030 SHALL verify: x1=8'h80, x2=8'h01, bin=0 -> y=8'h7F, bout=0, ovf=1.
REQ-031 SHALL verify: x1=8'h3C, x2=8'h3B, bin=1 -> y=8'h00, zero=1, bout=0, ovf=0.
REQ-032 SHALL verify: start with 8'h10-8'h01, then start with 8'hFF-8'hFF during busy -> single done, y=8'h0F.
REQ-033 SHALL verify: rst on 4th RUN cycle -> next cycle busy=0, done=0, y=8'h00, no done pulse; a following start completes normally.
